// File: rtl/cpu_controller_if.sv
// Control bundle between the sequencer and the accumulator datapath:
// opcode/zero flow in, strobes and the debug phase flow out.
interface cpu_controller_if;
    logic [2:0] opcode;
    logic       zero;
    logic       sel;
    logic       mem_rd;
    logic       load_ir;
    logic       inc_pc;
    logic       load_pc;
    logic       load_ac;
    logic       mem_wr;
    logic       data_e;
    logic       halt;
    logic [2:0] phase;

    modport master (
        input  opcode, zero,
        output sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt, phase
    );

    modport slave (
        output opcode, zero,
        input  sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt, phase
    );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase fetch/execute sequencer for the 8-bit accumulator CPU.
// Strobes are decoded from the registered phase, the opcode and the ALU zero flag.
module cpu_controller (
    input  logic             clk,
    input  logic             rst,
    cpu_controller_if.master bus
);
    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [3:0] {
        S_INST_ADDR  = 4'd0,
        S_INST_FETCH = 4'd1,
        S_INST_LOAD  = 4'd2,
        S_IDLE       = 4'd3,
        S_OP_ADDR    = 4'd4,
        S_OP_FETCH   = 4'd5,
        S_ALU_OP     = 4'd6,
        S_STORE      = 4'd7,
        S_HALTED     = 4'd8
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_aluop;
    logic       w_sel, w_mem_rd, w_load_ir, w_inc_pc, w_load_pc;
    logic       w_load_ac, w_mem_wr, w_data_e, w_halt;
    logic [2:0] w_phase;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INST_ADDR;
        else     r_state <= w_next;
    end

    assign w_aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                     (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

    always_comb begin
        w_next    = r_state;
        w_sel     = 1'b0;
        w_mem_rd  = 1'b0;
        w_load_ir = 1'b0;
        w_inc_pc  = 1'b0;
        w_load_pc = 1'b0;
        w_load_ac = 1'b0;
        w_mem_wr  = 1'b0;
        w_data_e  = 1'b0;
        w_halt    = 1'b0;
        case (r_state)
            S_INST_ADDR: begin
                w_sel  = 1'b1;
                w_next = S_INST_FETCH;
            end
            S_INST_FETCH: begin
                w_sel    = 1'b1;
                w_mem_rd = 1'b1;
                w_next   = S_INST_LOAD;
            end
            S_INST_LOAD: begin
                w_sel     = 1'b1;
                w_mem_rd  = 1'b1;
                w_load_ir = 1'b1;
                w_next    = S_IDLE;
            end
            S_IDLE: begin
                w_sel     = 1'b1;
                w_mem_rd  = 1'b1;
                w_load_ir = 1'b1;
                w_next    = S_OP_ADDR;
            end
            // HLT still bumps the PC so execution resumes past it after reset
            S_OP_ADDR: begin
                w_inc_pc = 1'b1;
                w_halt   = (bus.opcode == OP_HLT);
                w_next   = (bus.opcode == OP_HLT) ? S_HALTED : S_OP_FETCH;
            end
            S_OP_FETCH: begin
                w_mem_rd = w_aluop;
                w_next   = S_ALU_OP;
            end
            S_ALU_OP: begin
                w_mem_rd  = w_aluop;
                w_inc_pc  = (bus.opcode == OP_SKZ) && bus.zero;
                w_load_pc = (bus.opcode == OP_JMP);
                w_data_e  = (bus.opcode == OP_STO);
                w_next    = S_STORE;
            end
            S_STORE: begin
                w_mem_rd  = w_aluop;
                w_load_ac = w_aluop;
                w_load_pc = (bus.opcode == OP_JMP);
                w_mem_wr  = (bus.opcode == OP_STO);
                w_data_e  = (bus.opcode == OP_STO);
                w_next    = S_INST_ADDR;
            end
            S_HALTED: begin
                w_halt = 1'b1;
                w_next = S_HALTED;
            end
            default: w_next = S_INST_ADDR;
        endcase
    end

    // HALTED is an internal ninth state; it reports as the OP_ADDR phase
    assign w_phase = (r_state == S_HALTED) ? 3'd4 : r_state[2:0];

    assign bus.sel     = w_sel;
    assign bus.mem_rd  = w_mem_rd;
    assign bus.load_ir = w_load_ir;
    assign bus.inc_pc  = w_inc_pc;
    assign bus.load_pc = w_load_pc;
    assign bus.load_ac = w_load_ac;
    assign bus.mem_wr  = w_mem_wr;
    assign bus.data_e  = w_data_e;
    assign bus.halt    = w_halt;
    assign bus.phase   = w_phase;
endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: a phase-tracking reference model pushes the
// expected strobe vector each cycle and the observed outputs are popped against it.
module tb_cpu_controller;
    localparam logic [2:0] HLT = 3'd0;
    localparam logic [2:0] SKZ = 3'd1;
    localparam logic [2:0] ADD = 3'd2;
    localparam logic [2:0] AND = 3'd3;
    localparam logic [2:0] XOR = 3'd4;
    localparam logic [2:0] LDA = 3'd5;
    localparam logic [2:0] STO = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_controller_if bus();
    cpu_controller dut (.clk(clk), .rst(rst), .bus(bus));

    int          vectors = 0;
    int          miscompares = 0;
    int          mst;
    logic [11:0] sb_q[$];

    // Vector layout: {sel, mem_rd, load_ir, inc_pc, load_pc, load_ac, mem_wr, data_e, halt, phase[2:0]}
    function automatic logic [11:0] model(int st, logic [2:0] op, logic z);
        logic sel, rd, ir, inc, ldpc, ldac, wr, de, hl, aluop;
        logic [2:0] ph;
        {sel, rd, ir, inc, ldpc, ldac, wr, de, hl} = '0;
        aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
        ph = (st == 8) ? 3'd4 : 3'(st);
        case (st)
            0: sel = 1'b1;
            1: begin sel = 1'b1; rd = 1'b1; end
            2: begin sel = 1'b1; rd = 1'b1; ir = 1'b1; end
            3: begin sel = 1'b1; rd = 1'b1; ir = 1'b1; end
            4: begin inc = 1'b1; hl = (op == HLT); end
            5: rd = aluop;
            6: begin rd = aluop; inc = (op == SKZ) && z; ldpc = (op == JMP); de = (op == STO); end
            7: begin rd = aluop; ldac = aluop; ldpc = (op == JMP); wr = (op == STO); de = (op == STO); end
            default: hl = 1'b1;
        endcase
        return {sel, rd, ir, inc, ldpc, ldac, wr, de, hl, ph};
    endfunction

    function automatic int model_next(int st, logic [2:0] op);
        if (st == 8) return 8;
        if (st == 4 && op == HLT) return 8;
        return (st + 1) % 8;
    endfunction

    task automatic step(input logic [2:0] op, input logic z, input logic r, input string tag);
        logic [11:0] obs, exp_v;
        @(negedge clk);
        bus.opcode = op;
        bus.zero   = z;
        rst        = r;
        sb_q.push_back(model(mst, op, z));
        #1;
        obs = {bus.sel, bus.mem_rd, bus.load_ir, bus.inc_pc, bus.load_pc,
               bus.load_ac, bus.mem_wr, bus.data_e, bus.halt, bus.phase};
        exp_v = sb_q.pop_front();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s st=%0d observed=%b expected=%b", tag, mst, obs, exp_v);
        end
        mst = r ? 0 : model_next(mst, op);
    endtask

    // One full instruction; phases 0-1 see a random opcode that must be ignored
    task automatic instr(input logic [2:0] op, input logic z, input string tag);
        for (int p = 0; p < 8; p++)
            step((p < 2) ? 3'($urandom_range(7)) : op, z, 1'b0, tag);
    endtask

    initial begin
        rst        = 1'b1;
        bus.opcode = HLT;
        bus.zero   = 1'b0;
        @(posedge clk);
        mst = 0;

        instr(ADD, 1'b0, "add");
        instr(STO, 1'b0, "sto");
        instr(SKZ, 1'b1, "skz_z1");
        instr(SKZ, 1'b0, "skz_z0");
        instr(JMP, 1'b1, "jmp");
        instr(LDA, 1'b1, "lda");
        instr(AND, 1'b0, "and");
        instr(XOR, 1'b1, "xor");
        instr(STO, 1'b1, "sto_z1");

        for (int p = 0; p < 5; p++) step(HLT, 1'b0, 1'b0, "hlt_enter");
        for (int k = 0; k < 20; k++) step(3'($urandom_range(7)), 1'($urandom_range(1)), 1'b0, "hlt_park");
        step(ADD, 1'b0, 1'b1, "hlt_rst");
        instr(ADD, 1'b0, "after_hlt");

        for (int p = 0; p < 6; p++) step(STO, 1'b0, 1'b0, "sto_pre_rst");
        step(STO, 1'b0, 1'b1, "sto_rst_p6");
        instr(STO, 1'b0, "sto_resume");
        instr(SKZ, 1'b1, "skz_resume");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
